// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared codes and the FSM state type for the memory-stage load/store controller.
// The misalignment rule lives here so the controller and any future users agree on it.
package dmem_lsu_ctrl_pkg;

  localparam logic [2:0] LS_W  = 3'b000;
  localparam logic [2:0] LS_B  = 3'b001;
  localparam logic [2:0] LS_BU = 3'b010;
  localparam logic [2:0] LS_H  = 3'b011;
  localparam logic [2:0] LS_HU = 3'b100;

  localparam logic [1:0] SS_W = 2'b00;
  localparam logic [1:0] SS_B = 2'b01;
  localparam logic [1:0] SS_H = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsuState_t;

  // Byte accesses never fault; the reserved store code behaves like sw.
  function automatic logic isMisaligned(input logic isStore, input logic [2:0] loadSize,
                                        input logic [1:0] storeSize, input logic [1:0] byteOff);
    logic mis;
    mis = 1'b0;
    if (isStore) begin
      case (storeSize)
        SS_B:    mis = 1'b0;
        SS_H:    mis = byteOff[0];
        SS_W:    mis = |byteOff;
        default: mis = |byteOff;
      endcase
    end else begin
      case (loadSize)
        LS_W:        mis = |byteOff;
        LS_H, LS_HU: mis = byteOff[0];
        LS_B, LS_BU: mis = 1'b0;
        default:     mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_store_lane_gen.sv
// Combinational byte-enable and lane-replicated store data generator.
// Replicating the source across lanes lets the memory pick bytes purely by enable.
module dmem_lsu_ctrl_store_lane_gen
  import dmem_lsu_ctrl_pkg::*;
(
  input  logic [1:0]  byteOff,
  input  logic [1:0]  storeSize,
  input  logic [31:0] storeData,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  logic [31:0] byteWord;
  logic [31:0] halfWord;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gByteLane
      assign byteWord[8*gi +: 8] = storeData[7:0];
    end
    for (gi = 0; gi < 2; gi++) begin : gHalfLane
      assign halfWord[16*gi +: 16] = storeData[15:0];
    end
  endgenerate

  always_comb begin
    be    = 4'b1111;
    wdata = storeData;
    case (storeSize)
      SS_B: begin
        be    = 4'b0001 << byteOff;
        wdata = byteWord;
      end
      SS_H: begin
        be    = byteOff[1] ? 4'b1100 : 4'b0011;
        wdata = halfWord;
      end
      default: begin
        be    = 4'b1111;
        wdata = storeData;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// M-stage load/store controller: req/gnt/rvalid handshake with a variable-latency
// data memory, pipeline stall generation, timeout abort and capture for the load converter.
module dmem_lsu_ctrl
  import dmem_lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  LoadSizeM,
  input  logic [1:0]  StoreSizeM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataMTick,
  output logic [1:0]  ByteNum,
  output logic [2:0]  LoadSize
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsuState_t   stateReg;
  lsuState_t   stateNext;
  logic [7:0]  timeoutCntReg;
  logic [3:0]  laneBe;
  logic [31:0] laneWdata;

  logic access;
  logic isStore;
  logic misaligned;
  logic launch;
  logic busy;
  logic rdDone;
  logic wrDone;
  logic abort;

  // A simultaneous read and write request resolves to the store.
  assign access     = MemReadM | MemWriteM;
  assign isStore    = MemWriteM;
  assign misaligned = isMisaligned(isStore, LoadSizeM, StoreSizeM, ALUResultM[1:0]);
  assign launch     = (stateReg == IDLE) && access && !misaligned;
  assign busy       = (stateReg == REQ) || (stateReg == WAIT);

  assign wrDone = (stateReg == REQ) && dmem_gnt && dmem_we;
  assign rdDone = ((stateReg == REQ) && dmem_gnt && !dmem_we && dmem_rvalid)
               || ((stateReg == WAIT) && dmem_rvalid);
  // A response on the final permitted cycle still wins over the abort.
  assign abort  = busy && !rdDone && !wrDone && (timeoutCntReg == TIMEOUT_LAST);

  dmem_lsu_ctrl_store_lane_gen uLaneGen (
    .byteOff   (ALUResultM[1:0]),
    .storeSize (StoreSizeM),
    .storeData (WriteDataM),
    .be        (laneBe),
    .wdata     (laneWdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (launch) stateNext = REQ;
      REQ: begin
        if (wrDone || rdDone || abort) stateNext = DONE;
        else if (dmem_gnt)             stateNext = WAIT;
      end
      WAIT: if (rdDone || abort) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    StallM    = launch || busy;
    MisalignM = (stateReg == IDLE) && access && misaligned;
    dmem_req  = (stateReg == REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= 4'b0000;
      ByteNum       <= 2'b00;
      LoadSize      <= 3'b000;
      ReadDataMTick <= '0;
      BusErrM       <= 1'b0;
      timeoutCntReg <= '0;
    end else begin
      BusErrM <= abort;
      if (launch) begin
        dmem_addr  <= {ALUResultM[31:2], 2'b00};
        dmem_we    <= isStore;
        dmem_be    <= isStore ? laneBe : 4'b1111;
        dmem_wdata <= isStore ? laneWdata : 32'h0;
        if (!isStore) begin
          ByteNum  <= ALUResultM[1:0];
          LoadSize <= LoadSizeM;
        end
      end
      if (rdDone) begin
        ReadDataMTick <= dmem_rdata;
      end else if (abort) begin
        ReadDataMTick <= '0;
      end
      if (launch) begin
        timeoutCntReg <= '0;
      end else if (busy) begin
        timeoutCntReg <= timeoutCntReg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl: loads, stores, bus stalls, misalignment,
// timeout abort and reset during an outstanding read.
module tb_dmem_lsu_ctrl;

  logic        clk;
  logic        reset_n;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  LoadSizeM;
  logic [1:0]  StoreSizeM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] ReadDataMTick;
  logic [1:0]  ByteNum;
  logic [2:0]  LoadSize;

  int nTests = 0;
  int nFail  = 0;

  dmem_lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .MemReadM      (MemReadM),
    .MemWriteM     (MemWriteM),
    .ALUResultM    (ALUResultM),
    .WriteDataM    (WriteDataM),
    .LoadSizeM     (LoadSizeM),
    .StoreSizeM    (StoreSizeM),
    .StallM        (StallM),
    .MisalignM     (MisalignM),
    .BusErrM       (BusErrM),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .ReadDataMTick (ReadDataMTick),
    .ByteNum       (ByteNum),
    .LoadSize      (LoadSize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load with gnt on the first request cycle and rvalid one cycle later.
  task automatic runLoad(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] rdata);
    MemReadM = 1'b1; ALUResultM = addr; LoadSizeM = size;
    #1;
    check("ld_idle_stall", 32'(StallM), 32'd1);
    check("ld_idle_req", 32'(dmem_req), 32'd0);
    step();
    dmem_gnt = 1'b1;
    #1;
    check("ld_req", 32'(dmem_req), 32'd1);
    check("ld_req_stall", 32'(StallM), 32'd1);
    check("ld_addr", dmem_addr, {addr[31:2], 2'b00});
    check("ld_we", 32'(dmem_we), 32'd0);
    check("ld_be", 32'(dmem_be), 32'hF);
    check("ld_bytenum", 32'(ByteNum), 32'(addr[1:0]));
    check("ld_loadsize", 32'(LoadSize), 32'(size));
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    #1;
    check("ld_wait_req", 32'(dmem_req), 32'd0);
    check("ld_wait_stall", 32'(StallM), 32'd1);
    step();
    dmem_rvalid = 1'b0; MemReadM = 1'b0;
    #1;
    check("ld_done_stall", 32'(StallM), 32'd0);
    check("ld_rdata", ReadDataMTick, rdata);
    check("ld_buserr", 32'(BusErrM), 32'd0);
    step();
    $display("[TB] load addr=0x%08h size=%0d rdata=0x%08h", addr, size, ReadDataMTick);
  endtask

  // Store held off by gntDelay cycles of gnt low; bus outputs must stay stable meanwhile.
  task automatic runStore(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                          input int gntDelay, input logic alsoRead,
                          input logic [3:0] expBe, input logic [31:0] expWdata,
                          input logic [31:0] expRd);
    MemWriteM = 1'b1; MemReadM = alsoRead; ALUResultM = addr; StoreSizeM = size; WriteDataM = data;
    LoadSizeM = 3'b000;
    #1;
    check("st_idle_stall", 32'(StallM), 32'd1);
    check("st_idle_misalign", 32'(MisalignM), 32'd0);
    step();
    for (int i = 0; i <= gntDelay; i++) begin
      if (i == gntDelay) dmem_gnt = 1'b1;
      #1;
      check("st_req", 32'(dmem_req), 32'd1);
      check("st_stall", 32'(StallM), 32'd1);
      check("st_we", 32'(dmem_we), 32'd1);
      check("st_addr", dmem_addr, {addr[31:2], 2'b00});
      check("st_be", 32'(dmem_be), 32'(expBe));
      check("st_wdata", dmem_wdata, expWdata);
      step();
    end
    dmem_gnt = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0;
    #1;
    check("st_done_stall", 32'(StallM), 32'd0);
    check("st_done_req", 32'(dmem_req), 32'd0);
    check("st_keeps_rdata", ReadDataMTick, expRd);
    step();
    $display("[TB] store addr=0x%08h size=%0d be=%04b wdata=0x%08h", addr, size, expBe, expWdata);
  endtask

  initial begin
    reset_n = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
    LoadSizeM = '0; StoreSizeM = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    step(); step();
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_rdata", ReadDataMTick, 32'd0);
    check("rst_buserr", 32'(BusErrM), 32'd0);
    reset_n = 1'b1;
    step();
    $display("[TB] reset released");

    runLoad(32'h0000_1003, 3'b001, 32'h80FF_1234);
    runStore(32'h0000_2002, 2'b10, 32'hAAAA_5678, 0, 1'b0, 4'b1100, 32'h5678_5678, 32'h80FF_1234);
    runStore(32'h0000_4000, 2'b00, 32'h1234_5678, 4, 1'b0, 4'b1111, 32'h1234_5678, 32'h80FF_1234);
    runStore(32'h0000_5002, 2'b01, 32'h0000_00AB, 1, 1'b1, 4'b0100, 32'hABAB_ABAB, 32'h80FF_1234);

    // Misaligned lw and sh: flagged, no request, no stall.
    MemReadM = 1'b1; LoadSizeM = 3'b000; ALUResultM = 32'h0000_3001;
    #1;
    check("mis_lw_flag", 32'(MisalignM), 32'd1);
    check("mis_lw_stall", 32'(StallM), 32'd0);
    step();
    check("mis_lw_req", 32'(dmem_req), 32'd0);
    MemReadM = 1'b0; MemWriteM = 1'b1; StoreSizeM = 2'b10; ALUResultM = 32'h0000_2001;
    #1;
    check("mis_sh_flag", 32'(MisalignM), 32'd1);
    check("mis_sh_stall", 32'(StallM), 32'd0);
    step();
    check("mis_sh_req", 32'(dmem_req), 32'd0);
    MemWriteM = 1'b0;
    $display("[TB] misaligned lw@0x3001 and sh@0x2001 rejected");

    // Timeout: one REQ cycle with gnt, then seven WAIT cycles without rvalid.
    MemReadM = 1'b1; LoadSizeM = 3'b000; ALUResultM = 32'h0000_6000;
    step();
    dmem_gnt = 1'b1;
    #1;
    check("to_req_stall", 32'(StallM), 32'd1);
    step();
    dmem_gnt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("to_wait_stall", 32'(StallM), 32'd1);
      check("to_wait_buserr", 32'(BusErrM), 32'd0);
      step();
    end
    MemReadM = 1'b0;
    #1;
    check("to_buserr", 32'(BusErrM), 32'd1);
    check("to_done_stall", 32'(StallM), 32'd0);
    check("to_done_req", 32'(dmem_req), 32'd0);
    check("to_rdata_zero", ReadDataMTick, 32'd0);
    step();
    check("to_buserr_pulse", 32'(BusErrM), 32'd0);
    check("to_idle_stall", 32'(StallM), 32'd0);
    $display("[TB] load addr=0x00006000 timed out");

    // Reset while a halfword load waits for rvalid; a late rvalid must be ignored.
    runLoad(32'h0000_7004, 3'b000, 32'hDEAD_BEEF);
    MemReadM = 1'b1; LoadSizeM = 3'b011; ALUResultM = 32'h0000_7006;
    step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1;
    check("rw_wait_stall", 32'(StallM), 32'd1);
    check("rw_bytenum", 32'(ByteNum), 32'd2);
    reset_n = 1'b0; MemReadM = 1'b0;
    #1;
    check("rw_req", 32'(dmem_req), 32'd0);
    check("rw_stall", 32'(StallM), 32'd0);
    check("rw_rdata", ReadDataMTick, 32'd0);
    check("rw_addr", dmem_addr, 32'd0);
    check("rw_be", 32'(dmem_be), 32'd0);
    check("rw_bytenum_rst", 32'(ByteNum), 32'd0);
    check("rw_loadsize_rst", 32'(LoadSize), 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    #1;
    check("late_rv_stall", 32'(StallM), 32'd0);
    step();
    dmem_rvalid = 1'b0;
    #1;
    check("late_rv_rdata", ReadDataMTick, 32'd0);
    check("late_rv_req", 32'(dmem_req), 32'd0);
    $display("[TB] reset during WAIT, late rvalid ignored");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Memory-stage load/store controller sitting directly upstream of the load size converter.
- Takes the M-stage access (address, store data, access size) and runs a req/gnt/rvalid handshake with a variable-latency data memory.
- Stalls the pipeline while an access is outstanding.
- Presents the raw read word, byte offset and load-size code to the size converter.
- Generates byte enables and lane-replicated store data for sb/sh/sw.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before the access is aborted as a bus error (1..255).

Ports:
- clk  in  1  system clock; single clock domain, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- MemReadM  in  1  M-stage load.
- MemWriteM  in  1  M-stage store.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store source (rs2).
- LoadSizeM  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu.
- StoreSizeM  in  2  00 sw, 01 sb, 10 sh, 11 reserved (treated as sw).
- StallM  out  1  hold F/D/E/M stages.
- MisalignM  out  1  misaligned access flag (combinational, no bus access).
- BusErrM  out  1  one-cycle pulse on timeout abort.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, {addr[31:2],2'b00}.
- dmem_wdata  out  32  replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read word.
- ReadDataMTick  out  32  captured raw read word (to converter).
- ByteNum  out  2  captured addr[1:0].
- LoadSize  out  3  captured LoadSizeM.

Behaviour:
- Reset values:
  - State = IDLE.
  - dmem_req, dmem_we, BusErrM = 0.
  - dmem_addr, dmem_wdata, ReadDataMTick = 0.
  - dmem_be = 0000; ByteNum = 00; LoadSize = 000.
  - Timeout counter = 0.
- Access and precedence:
  - access = MemReadM | MemWriteM.
  - If both MemReadM and MemWriteM are high, the store is performed.
- Misalignment (combinational in IDLE):
  - Flagged for lw/sw with addr[1:0]!=0, and for lh/lhu/sh with addr[0]!=0.
  - On a misaligned access: MisalignM = 1, no request issued, StallM = 0.
- StallM = (IDLE & access & !MisalignM) | REQ | WAIT.
- States:
  - IDLE: on an aligned access, register dmem_addr/we/be/wdata, ByteNum and LoadSize, clear the counter, go to REQ.
  - REQ: dmem_req = 1 with all bus outputs held stable until gnt.
    - gnt & write -> DONE (posted write).
    - gnt & read & rvalid in the same cycle -> capture rdata, go to DONE.
    - gnt & read without rvalid -> WAIT.
  - WAIT: dmem_req = 0; on rvalid, capture dmem_rdata into ReadDataMTick and go to DONE.
  - DONE: StallM = 0 for exactly one cycle so the pipeline advances; next state is IDLE. No new request is evaluated in DONE.
- Latency: a load with gnt at first request and rvalid one cycle later gives 3 stall cycles (IDLE, REQ, WAIT), then DONE. A store with immediate gnt gives 2 stall cycles.
- Timeout:
  - The counter increments in REQ and WAIT.
  - When it reaches TIMEOUT_CYCLES: BusErrM = 1 for one cycle, ReadDataMTick = 0, req drops, go to DONE.
- Store byte enables and data:
  - sb: be = 0001 << addr[1:0]; wdata = {4{WriteDataM[7:0]}}.
  - sh: be = addr[1] ? 1100 : 0011; wdata = {2{WriteDataM[15:0]}}.
  - sw: be = 1111; wdata = WriteDataM.
  - Reads: be = 1111.
- Hold rules: ReadDataMTick, ByteNum and LoadSize hold their values until the next load completes. Stores do not alter ReadDataMTick.
- Reset mid-transaction: immediate return to IDLE with req low. The memory-side request is abandoned; a late rvalid arriving in IDLE is ignored.
- gnt or rvalid in IDLE or DONE: ignored.

Decomposition:
- Shared package holds:
  - LoadSize codes (LS_W, LS_B, LS_BU, LS_H, LS_HU).
  - StoreSize codes (SS_W, SS_B, SS_H).
  - FSM state enum (IDLE, REQ, WAIT, DONE).
- One natural sub-module: store_lane_gen, a combinational generator of be and wdata from addr[1:0], StoreSizeM and WriteDataM.

Test Plan:
- lb at 0x1003, gnt immediate, rvalid next cycle with rdata 0x80FF1234 -> StallM high 3 cycles; ReadDataMTick = 0x80FF1234, ByteNum = 11, LoadSize = 001.
- sh at 0x2002, WriteDataM = 0xAAAA5678 -> dmem_be = 1100, dmem_wdata = 0x56785678, dmem_addr = 0x2000, dmem_we = 1; StallM low in DONE.
- gnt held low 4 cycles on sw -> dmem_req and all bus outputs stable for 4 cycles; StallM held; one DONE cycle after gnt.
- lw at 0x3001 -> MisalignM = 1, dmem_req stays 0, StallM = 0.
- Load with rvalid never asserted, TIMEOUT_CYCLES = 8 -> BusErrM pulses after 8 REQ+WAIT cycles; ReadDataMTick = 0; FSM returns to IDLE via DONE.
- reset_n low while in WAIT, then late rvalid -> state IDLE, outputs at reset values, rvalid ignored.
